// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Purpose  : Load/store unit between the execute and memory stages. It turns
//            an execute-stage access into a word-aligned data-memory bus
//            request with byte mask and lane-replicated store data. It tracks
//            the request/response handshake and returns the raw read word to
//            the memory stage.
// Ports    : clk_i, rst_i              clock, synchronous active-high reset
//            ex_*_i                     access from the execute/memory register
//            advance_i                  pipeline register loads a new instr
//            bus_req_* / bus_resp_*     data-memory bus request/response
//            bus_addr/we/wmask/wdata_o  request payload (combinational)
//            dmem_rdata_o, dmem_resp_o  result to the memory stage
//            misalign_o                 misaligned-access flag
//                                       (only with ORION_LSU_MISALIGN_EN)
// Config   : define ORION_LSU_MISALIGN_EN to trap misaligned halfword/word
//            accesses without issuing them on the bus.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
   parameter int XLEN  = 32,
   parameter int ADDRW = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ex_valid_i,
   input  logic             ex_is_load_i,
   input  logic             ex_is_store_i,
   input  logic [ADDRW-1:0] ex_addr_i,
   input  logic [XLEN-1:0]  ex_wdata_i,
   input  logic [2:0]       ex_ls_type_i,
   input  logic             advance_i,
   output logic             bus_req_valid_o,
   input  logic             bus_req_ready_i,
   output logic [ADDRW-1:0] bus_addr_o,
   output logic             bus_we_o,
   output logic [3:0]       bus_wmask_o,
   output logic [XLEN-1:0]  bus_wdata_o,
   input  logic             bus_resp_valid_i,
   input  logic [XLEN-1:0]  bus_rdata_i,
   output logic [XLEN-1:0]  dmem_rdata_o,
`ifdef ORION_LSU_MISALIGN_EN
   output logic             misalign_o,
`endif
   output logic             dmem_resp_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [XLEN-1:0]   r_rdata_q;
   logic              w_access;
   logic              w_misalign;
   logic [3:0]        w_wmask;
   logic [XLEN-1:0]   w_wdata;

   assign w_access = ex_valid_i & (ex_is_load_i | ex_is_store_i);

`ifdef ORION_LSU_MISALIGN_EN
   // Halfword encodings are 001/101, word is 010.
   always_comb begin
      w_misalign = 1'b0;
      if (w_access) begin
         if ((ex_ls_type_i == 3'b001 || ex_ls_type_i == 3'b101) && ex_addr_i[0])
            w_misalign = 1'b1;
         else if (ex_ls_type_i == 3'b010 && ex_addr_i[1:0] != 2'b00)
            w_misalign = 1'b1;
      end
   end
   assign misalign_o = w_misalign & ~rst_i & (r_state == S_IDLE);
`else
   assign w_misalign = 1'b0;
`endif

   // Store lane steering: replicate the data across all lanes so the byte
   // mask alone selects which lanes the memory actually writes.
   always_comb begin
      w_wmask = 4'b0000;
      w_wdata = ex_wdata_i;
      case (ex_ls_type_i)
         3'b000: begin
            w_wdata = {4{ex_wdata_i[7:0]}};
            w_wmask = 4'b0001 << ex_addr_i[1:0];
         end
         3'b001: begin
            w_wdata = {2{ex_wdata_i[15:0]}};
            w_wmask = 4'b0011 << {ex_addr_i[1], 1'b0};
         end
         3'b010: begin
            w_wdata = ex_wdata_i;
            w_wmask = 4'b1111;
         end
         default: begin
            w_wdata = ex_wdata_i;
            w_wmask = 4'b0000;
         end
      endcase
   end

   assign bus_addr_o  = {ex_addr_i[ADDRW-1:2], 2'b00};
   assign bus_we_o    = ex_is_store_i;
   assign bus_wmask_o = ex_is_store_i ? w_wmask : 4'b0000;
   assign bus_wdata_o = w_wdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_rdata_q <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_WAIT && bus_resp_valid_i)
            r_rdata_q <= bus_rdata_i;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      bus_req_valid_o = 1'b0;
      dmem_resp_o     = 1'b0;
      dmem_rdata_o    = '0;
      case (r_state)
         S_IDLE: begin
            // A trapped misaligned access completes immediately with zero
            // data so the memory stage can retire it.
            bus_req_valid_o = w_access & ~w_misalign & ~rst_i;
            dmem_resp_o     = w_misalign & ~rst_i;
            if (bus_req_valid_o && bus_req_ready_i)
               w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            dmem_resp_o  = bus_resp_valid_i & ~rst_i;
            dmem_rdata_o = rst_i ? '0 : bus_rdata_i;
            if (bus_resp_valid_i)
               w_state_nxt = advance_i ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            // Hold the result until the pipeline moves; never reissue.
            dmem_resp_o  = ~rst_i;
            dmem_rdata_o = rst_i ? '0 : r_rdata_q;
            if (advance_i)
               w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Purpose  : Directed self-checking testbench for dmem_lsu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ex_valid_i;
   logic        ex_is_load_i;
   logic        ex_is_store_i;
   logic [31:0] ex_addr_i;
   logic [31:0] ex_wdata_i;
   logic [2:0]  ex_ls_type_i;
   logic        advance_i;
   logic        bus_req_valid_o;
   logic        bus_req_ready_i;
   logic [31:0] bus_addr_o;
   logic        bus_we_o;
   logic [3:0]  bus_wmask_o;
   logic [31:0] bus_wdata_o;
   logic        bus_resp_valid_i;
   logic [31:0] bus_rdata_i;
   logic [31:0] dmem_rdata_o;
   logic        dmem_resp_o;
`ifdef ORION_LSU_MISALIGN_EN
   logic        misalign_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   dmem_lsu #(.XLEN(32), .ADDRW(32)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .ex_valid_i       (ex_valid_i),
      .ex_is_load_i     (ex_is_load_i),
      .ex_is_store_i    (ex_is_store_i),
      .ex_addr_i        (ex_addr_i),
      .ex_wdata_i       (ex_wdata_i),
      .ex_ls_type_i     (ex_ls_type_i),
      .advance_i        (advance_i),
      .bus_req_valid_o  (bus_req_valid_o),
      .bus_req_ready_i  (bus_req_ready_i),
      .bus_addr_o       (bus_addr_o),
      .bus_we_o         (bus_we_o),
      .bus_wmask_o      (bus_wmask_o),
      .bus_wdata_o      (bus_wdata_o),
      .bus_resp_valid_i (bus_resp_valid_i),
      .bus_rdata_i      (bus_rdata_i),
      .dmem_rdata_o     (dmem_rdata_o),
`ifdef ORION_LSU_MISALIGN_EN
      .misalign_o       (misalign_o),
`endif
      .dmem_resp_o      (dmem_resp_o)
   );

   task automatic drive_idle();
      ex_valid_i       = 1'b0;
      ex_is_load_i     = 1'b0;
      ex_is_store_i    = 1'b0;
      ex_addr_i        = 32'h0;
      ex_wdata_i       = 32'h0;
      ex_ls_type_i     = 3'b000;
      advance_i        = 1'b0;
      bus_req_ready_i  = 1'b0;
      bus_resp_valid_i = 1'b0;
      bus_rdata_i      = 32'h0;
   endtask

   task automatic drive_access(input logic is_load, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] ty);
      ex_valid_i    = 1'b1;
      ex_is_load_i  = is_load;
      ex_is_store_i = ~is_load;
      ex_addr_i     = addr;
      ex_wdata_i    = wdata;
      ex_ls_type_i  = ty;
   endtask

   task automatic test_reset();
      drive_idle();
      rst_i = 1'b1;
      drive_access(1'b1, 32'h1000, 32'h0, 3'b010);
      bus_req_ready_i = 1'b1;
      @(negedge clk_i); #1;
      n_tests++; if (bus_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", bus_req_valid_o); end
      n_tests++; if (dmem_resp_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp: got %b want 0", dmem_resp_o); end
      n_tests++; if (dmem_rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", dmem_rdata_o); end
      @(negedge clk_i);
      rst_i = 1'b0;
      drive_idle();
      #1;
      n_tests++; if (bus_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_req_valid: got %b want 0", bus_req_valid_o); end
      n_tests++; if (dmem_resp_o !== 1'b0) begin n_fail++; $display("FAIL idle_resp: got %b want 0", dmem_resp_o); end
   endtask

   task automatic test_lw();
      @(negedge clk_i);
      drive_access(1'b1, 32'h1000, 32'h0, 3'b010);
      bus_req_ready_i = 1'b1;
      #1;
      n_tests++; if (bus_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL lw_req_valid: got %b want 1", bus_req_valid_o); end
      n_tests++; if (bus_addr_o !== 32'h1000) begin n_fail++; $display("FAIL lw_addr: got %h want 00001000", bus_addr_o); end
      n_tests++; if (bus_wmask_o !== 4'b0000) begin n_fail++; $display("FAIL lw_wmask: got %b want 0000", bus_wmask_o); end
      n_tests++; if (bus_we_o !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b want 0", bus_we_o); end
      n_tests++; if (dmem_resp_o !== 1'b0) begin n_fail++; $display("FAIL lw_resp_issue: got %b want 0", dmem_resp_o); end
      @(negedge clk_i);
      bus_resp_valid_i = 1'b1;
      bus_rdata_i      = 32'hDEADBEEF;
      advance_i        = 1'b1;
      #1;
      n_tests++; if (bus_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL lw_wait_req: got %b want 0", bus_req_valid_o); end
      n_tests++; if (dmem_resp_o !== 1'b1) begin n_fail++; $display("FAIL lw_resp: got %b want 1", dmem_resp_o); end
      n_tests++; if (dmem_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", dmem_rdata_o); end
      @(negedge clk_i);
      drive_idle();
      #1;
      n_tests++; if (dmem_resp_o !== 1'b0) begin n_fail++; $display("FAIL lw_back_idle_resp: got %b want 0", dmem_resp_o); end
   endtask

   task automatic test_sb();
      @(negedge clk_i);
      drive_access(1'b0, 32'h2003, 32'h12345678, 3'b000);
      bus_req_ready_i = 1'b1;
      #1;
      n_tests++; if (bus_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL sb_req_valid: got %b want 1", bus_req_valid_o); end
      n_tests++; if (bus_wdata_o !== 32'h78787878) begin n_fail++; $display("FAIL sb_wdata: got %h want 78787878", bus_wdata_o); end
      n_tests++; if (bus_wmask_o !== 4'b1000) begin n_fail++; $display("FAIL sb_wmask: got %b want 1000", bus_wmask_o); end
      n_tests++; if (bus_we_o !== 1'b1) begin n_fail++; $display("FAIL sb_we: got %b want 1", bus_we_o); end
      n_tests++; if (bus_addr_o !== 32'h2000) begin n_fail++; $display("FAIL sb_addr: got %h want 00002000", bus_addr_o); end
      @(negedge clk_i);
      bus_resp_valid_i = 1'b1;
      advance_i        = 1'b1;
      #1;
      n_tests++; if (dmem_resp_o !== 1'b1) begin n_fail++; $display("FAIL sb_ack_resp: got %b want 1", dmem_resp_o); end
      @(negedge clk_i);
      drive_idle();
   endtask

   task automatic test_sh_stall();
      @(negedge clk_i);
      drive_access(1'b0, 32'h2002, 32'h0000ABCD, 3'b001);
      for (int i = 0; i < 4; i++) begin
         bus_req_ready_i = (i == 3);
         #1;
         n_tests++; if (bus_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL sh_hold_valid[%0d]: got %b want 1", i, bus_req_valid_o); end
         n_tests++; if (bus_addr_o !== 32'h2000) begin n_fail++; $display("FAIL sh_hold_addr[%0d]: got %h want 00002000", i, bus_addr_o); end
         n_tests++; if (bus_wmask_o !== 4'b1100) begin n_fail++; $display("FAIL sh_hold_wmask[%0d]: got %b want 1100", i, bus_wmask_o); end
         n_tests++; if (bus_wdata_o !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_hold_wdata[%0d]: got %h want abcdabcd", i, bus_wdata_o); end
         @(negedge clk_i);
      end
      // Accepted: one WAIT cycle with no response yet.
      bus_req_ready_i = 1'b0;
      #1;
      n_tests++; if (bus_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL sh_wait_req: got %b want 0", bus_req_valid_o); end
      n_tests++; if (dmem_resp_o !== 1'b0) begin n_fail++; $display("FAIL sh_wait_resp: got %b want 0", dmem_resp_o); end
      @(negedge clk_i);
      bus_resp_valid_i = 1'b1;
      advance_i        = 1'b1;
      #1;
      n_tests++; if (dmem_resp_o !== 1'b1) begin n_fail++; $display("FAIL sh_ack_resp: got %b want 1", dmem_resp_o); end
      @(negedge clk_i);
      drive_idle();
   endtask

   task automatic test_done_hold();
      @(negedge clk_i);
      drive_access(1'b1, 32'h3004, 32'h0, 3'b010);
      bus_req_ready_i = 1'b1;
      @(negedge clk_i);
      bus_req_ready_i  = 1'b0;
      bus_resp_valid_i = 1'b1;
      bus_rdata_i      = 32'h55AA55AA;
      #1;
      n_tests++; if (dmem_rdata_o !== 32'h55AA55AA) begin n_fail++; $display("FAIL done_bypass_rdata: got %h want 55aa55aa", dmem_rdata_o); end
      @(negedge clk_i);
      bus_resp_valid_i = 1'b0;
      bus_rdata_i      = 32'h11111111;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++; if (dmem_resp_o !== 1'b1) begin n_fail++; $display("FAIL done_resp[%0d]: got %b want 1", i, dmem_resp_o); end
         n_tests++; if (dmem_rdata_o !== 32'h55AA55AA) begin n_fail++; $display("FAIL done_rdata[%0d]: got %h want 55aa55aa", i, dmem_rdata_o); end
         n_tests++; if (bus_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL done_no_reissue[%0d]: got %b want 0", i, bus_req_valid_o); end
         @(negedge clk_i);
      end
      advance_i = 1'b1;
      #1;
      n_tests++; if (dmem_resp_o !== 1'b1) begin n_fail++; $display("FAIL done_adv_resp: got %b want 1", dmem_resp_o); end
      // Back-to-back: next access issues the cycle after the advance.
      @(negedge clk_i);
      advance_i = 1'b0;
      drive_access(1'b0, 32'h4000, 32'hCAFEF00D, 3'b010);
      #1;
      n_tests++; if (bus_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_req_valid: got %b want 1", bus_req_valid_o); end
      n_tests++; if (bus_wmask_o !== 4'b1111) begin n_fail++; $display("FAIL b2b_sw_wmask: got %b want 1111", bus_wmask_o); end
      n_tests++; if (dmem_resp_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_resp: got %b want 0", dmem_resp_o); end
      // Stray response in IDLE is dropped.
      @(negedge clk_i);
      drive_idle();
      bus_resp_valid_i = 1'b1;
      bus_rdata_i      = 32'h77777777;
      #1;
      n_tests++; if (dmem_resp_o !== 1'b0) begin n_fail++; $display("FAIL idle_drop_resp: got %b want 0", dmem_resp_o); end
      @(negedge clk_i);
      drive_idle();
   endtask

   task automatic test_reset_mid();
      @(negedge clk_i);
      drive_access(1'b1, 32'h5000, 32'h0, 3'b010);
      bus_req_ready_i = 1'b1;
      @(negedge clk_i);
      bus_req_ready_i = 1'b0;
      rst_i           = 1'b1;
      #1;
      n_tests++; if (dmem_resp_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp: got %b want 0", dmem_resp_o); end
      @(negedge clk_i);
      rst_i            = 1'b0;
      bus_resp_valid_i = 1'b1;
      bus_rdata_i      = 32'h99999999;
      #1;
      n_tests++; if (dmem_resp_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_resp: got %b want 0", dmem_resp_o); end
      n_tests++; if (bus_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle_req: got %b want 1", bus_req_valid_o); end
      @(negedge clk_i);
      bus_resp_valid_i = 1'b0;
      bus_req_ready_i  = 1'b1;
      @(negedge clk_i);
      bus_req_ready_i  = 1'b0;
      bus_resp_valid_i = 1'b1;
      bus_rdata_i      = 32'h0BADF00D;
      advance_i        = 1'b1;
      #1;
      n_tests++; if (dmem_resp_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_resp: got %b want 1", dmem_resp_o); end
      n_tests++; if (dmem_rdata_o !== 32'h0BADF00D) begin n_fail++; $display("FAIL rstmid_new_rdata: got %h want 0badf00d", dmem_rdata_o); end
      @(negedge clk_i);
      drive_idle();
   endtask

`ifdef ORION_LSU_MISALIGN_EN
   task automatic test_misalign();
      @(negedge clk_i);
      drive_access(1'b1, 32'h1002, 32'h0, 3'b010);
      bus_req_ready_i = 1'b1;
      #1;
      n_tests++; if (bus_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL mis_req_valid: got %b want 0", bus_req_valid_o); end
      n_tests++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", misalign_o); end
      n_tests++; if (dmem_resp_o !== 1'b1) begin n_fail++; $display("FAIL mis_resp: got %b want 1", dmem_resp_o); end
      n_tests++; if (dmem_rdata_o !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h want 0", dmem_rdata_o); end
      @(negedge clk_i);
      drive_idle();
   endtask
`else
   task automatic test_misalign();
      // Feature absent: a misaligned word load goes out on the bus.
      @(negedge clk_i);
      drive_access(1'b1, 32'h1002, 32'h0, 3'b010);
      #1;
      n_tests++; if (bus_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL nomis_req_valid: got %b want 1", bus_req_valid_o); end
      n_tests++; if (bus_addr_o !== 32'h1000) begin n_fail++; $display("FAIL nomis_addr: got %h want 00001000", bus_addr_o); end
      n_tests++; if (dmem_resp_o !== 1'b0) begin n_fail++; $display("FAIL nomis_resp: got %b want 0", dmem_resp_o); end
      @(negedge clk_i);
      drive_idle();
   endtask
`endif

   initial begin
      test_reset();
      test_lw();
      test_sb();
      test_sh_stall();
      test_done_hold();
      test_reset_mid();
      test_misalign();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
